int8pe_feeder: RTL and testbench
================================

INT8PE_FEEDER -- requirements
Module: int8pe_feeder

Interface
REQ-001 Parameter DEPTH, default 4: operand FIFO depth in vector pairs; power of two, 2..16.
REQ-002 Parameter PE_LAT, default 6: cycles from an operand pair on pe_a/pe_b to its full contribution at the PE final output.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin a dot-product job; sampled only in IDLE.
REQ-006 len  input  16  job length in vector pairs; captured with accepted start.
REQ-007 in_valid  input  1  operand pair offered.
REQ-008 in_a, in_b  input  64 each  8 int8 lanes; lane i = bits [8i+7:8i].
REQ-009 in_ready  output  1  FIFO can accept a pair this cycle.
REQ-010 pe_a, pe_b  output  64 each  registered lane operands to PE; lane i drives PE A_i/B_i.
REQ-011 pe_clr_n  output  1  active-low accumulator clear to PE.
REQ-012 sample  output  1  one-cycle pulse: PE result valid this cycle.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 Push on in_valid && in_ready; in_ready = FIFO not full, in any state, including IDLE (prefill allowed).
REQ-015 FSM states IDLE, CLEAR, FEED, DRAIN, DONE; encoding in shared package.
REQ-016 IDLE: start=1 captures len, moves to CLEAR; start outside IDLE ignored.
REQ-017 CLEAR: pe_clr_n=0 for exactly one cycle; next FEED if len!=0, else DRAIN.
REQ-018 FEED: pop one pair per cycle when FIFO non-empty and issued<len; popped pair on pe_a/pe_b next cycle (1-cycle latency).
REQ-019 FEED, FIFO empty: pe_a/pe_b driven to zero (bubble, contributes 0); issued count unchanged.
REQ-020 When issued reaches len, next state DRAIN; no further pops; pairs beyond len stay in FIFO for next job.
REQ-021 DRAIN: counts PE_LAT cycles, starting the cycle after the last pair appears on pe_a/pe_b; pe_a/pe_b = 0 throughout.
REQ-022 DONE: sample=1 for one cycle, then IDLE.
REQ-023 Simultaneous push and pop allowed; FIFO occupancy unchanged; no push accepted when full, even with a pop in the same cycle.
REQ-024 FIFO pointers wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-025 pe_a/pe_b zero whenever no pair is issued (IDLE, CLEAR, DRAIN, DONE, bubbles).
REQ-026 len=65535 legal; issued counter 16 bits, no wrap within a job.

Reset
REQ-027 rst_n low, any state: FSM->IDLE, FIFO emptied, counters 0, pe_a=pe_b=0, pe_clr_n=0, sample=0, busy=0, in_ready=0.
REQ-028 After rst_n release: pe_clr_n=1, in_ready=1 from first clock edge; job in progress is abandoned, no sample.

Structure
REQ-029 Package int8pe_pkg holds LANES=8, LANE_W=8, state enum, default PE_LAT.
REQ-030 FIFO is one sub-module, int8pe_fifo (synchronous, DEPTH x 128 bits, show-ahead read).
REQ-031 All outputs driven from registers; no combinational in->out path except in_ready from FIFO full flag.

Verification
REQ-032 Prefill 3 pairs (all lanes A=1, B=2), start len=3 -> pe_clr_n low 1 cycle, 3 consecutive issues, sample exactly PE_LAT+1 cycles after third issue; PE out = 48.
REQ-033 start len=0 -> CLEAR, DRAIN PE_LAT cycles, sample pulse, PE out = 0, pe_a never nonzero.
REQ-034 len=4, in_valid every other cycle -> zero bubbles between issues, issued=4, result equals 4 pairs only.
REQ-035 Offer 6 pairs, DEPTH=4, no start -> in_ready low after 4 pushes; start len=2 -> 2 popped, 2 remain, 2 more accepted.
REQ-036 rst_n low mid-FEED (issued=2 of 5) -> IDLE next edge, FIFO empty, no sample; new job len=1 completes normally.
REQ-037 start pulsed during FEED and DRAIN -> ignored; exactly one sample per accepted start.

Source files
------------

// File: rtl/int8pe_pkg.sv
// Shared constants and FSM encoding for the int8 PE operand feeder.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package int8pe_pkg;

  localparam int LANES      = 8;
  localparam int LANE_W     = 8;
  localparam int VEC_W      = LANES * LANE_W;
  localparam int PAIR_W     = 2 * VEC_W;
  localparam int PE_LAT_DEF = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/int8pe_fifo.sv
// Operand-pair FIFO, DEPTH entries of W bits, show-ahead head output.
// Latency: a pushed entry is visible on head_dat the cycle after the push.
// Backpressure: pushes are dropped while full; pops are ignored while empty.
module int8pe_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full     = (cnt == (AW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/int8pe_feeder.sv
// Feeds buffered int8 vector pairs to a dot-product PE, then waits out PE latency.
// Latency: popped pair appears on pe_a/pe_b next cycle; sample PE_LAT+1 cycles after last issue.
// Backpressure: in_ready drops only when the operand FIFO is full; empty FIFO issues zero bubbles.
module int8pe_feeder
  import int8pe_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PE_LAT = PE_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] len,
  input  logic        in_valid,
  input  logic [63:0] in_a,
  input  logic [63:0] in_b,
  output logic        in_ready,
  output logic [63:0] pe_a,
  output logic [63:0] pe_b,
  output logic        pe_clr_n,
  output logic        sample,
  output logic        busy
);

  localparam logic [15:0] LAT16 = 16'(PE_LAT);

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [15:0]         issued_q, issued_d;
  logic [15:0]         drain_q, drain_d;
  logic                pop;
  logic                push;
  logic                rdy_q;
  logic                full;
  logic                empty;
  logic [PAIR_W-1:0]   head;

  // Ready is held low through reset and rises on the first edge afterwards.
  assign in_ready = rdy_q && !full;
  assign push     = in_valid && in_ready;

  int8pe_fifo #(
    .DEPTH (DEPTH),
    .W     (PAIR_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat ({in_a, in_b}),
    .pop      (pop),
    .head_dat (head),
    .full     (full),
    .empty    (empty)
  );

  // State and job counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      issued_q <= '0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      drain_q  <= drain_d;
    end
  end

  // Next-state logic; the drain count starts at 1 for an empty job since no pair cycle precedes it.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    issued_d = issued_q;
    drain_d  = drain_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d    = len;
          issued_d = '0;
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        if (len_q != '0) begin
          state_d = FEED;
        end else begin
          state_d = DRAIN;
          drain_d = 16'd1;
        end
      end
      FEED: begin
        if (!empty) begin
          pop      = 1'b1;
          issued_d = issued_q + 16'd1;
          if (issued_q == len_q - 16'd1) begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end
      end
      DRAIN: begin
        if (drain_q == LAT16) state_d = DONE;
        else                  drain_d = drain_q + 16'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs, decoded from the next state so they align with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_a     <= '0;
      pe_b     <= '0;
      pe_clr_n <= 1'b0;
      sample   <= 1'b0;
      busy     <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      pe_a     <= pop ? head[PAIR_W-1:VEC_W] : '0;
      pe_b     <= pop ? head[VEC_W-1:0]      : '0;
      pe_clr_n <= (state_d != CLEAR);
      sample   <= (state_d == DONE);
      busy     <= (state_d != IDLE);
      rdy_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_int8pe_feeder.sv
// Directed bench: queue/PE model checked every cycle, plus literal per-job results.
// Latency: n/a.
// Backpressure: stimulus waits on in_ready before each offered pair.
module tb_int8pe_feeder;

  localparam int DEPTH  = 4;
  localparam int PE_LAT = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic        in_valid = 1'b0;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic        in_ready;
  logic [63:0] pe_a;
  logic [63:0] pe_b;
  logic        pe_clr_n;
  logic        sample;
  logic        busy;

  int8pe_feeder #(.DEPTH(DEPTH), .PE_LAT(PE_LAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_ready (in_ready),
    .pe_a     (pe_a),
    .pe_b     (pe_b),
    .pe_clr_n (pe_clr_n),
    .sample   (sample),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state.
  logic [127:0] q[$];
  bit  job_active = 0;
  bit  in_clear   = 0;
  int  job_len = 0, issued = 0, exp_acc = 0, acc = 0;
  int  last_result = 0, sample_cnt = 0, start_acc = 0, push_cnt = 0;
  int  clear_cyc = 0, last_issue_cyc = 0, cyc = 0, edges = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int dot(input logic [63:0] a, input logic [63:0] b);
    int s = 0;
    for (int i = 0; i < 8; i++) s += int'($signed(a[8*i +: 8])) * int'($signed(b[8*i +: 8]));
    return s;
  endfunction

  function automatic logic [63:0] rep(input logic [7:0] v);
    return {8{v}};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst_n) edges++;
  end

  // Per-cycle comparison against the queue and PE model.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      check("rst_pe_a", pe_a, 0);
      check("rst_pe_b", pe_b, 0);
      check("rst_pe_clr_n", pe_clr_n, 0);
      check("rst_sample", sample, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      q.delete();
      job_active = 0;
      in_clear = 0;
      issued = 0;
      acc = 0;
      edges = 0;
    end else begin
      bit was_active;
      bit exp_rdy;
      was_active = job_active;
      if (pe_a != 0 || pe_b != 0) begin
        if (!job_active || issued >= job_len || q.size() == 0) begin
          check("spurious_issue", 1, 0);
        end else begin
          check("issue_a", pe_a, q[0][127:64]);
          check("issue_b", pe_b, q[0][63:0]);
          exp_acc += dot(q[0][127:64], q[0][63:0]);
          void'(q.pop_front());
          issued++;
          last_issue_cyc = cyc;
        end
      end
      check("pe_clr_n", pe_clr_n, (edges > 0 && !in_clear) ? 1 : 0);
      if (in_clear) clear_cyc = cyc;
      in_clear = 0;
      if (!pe_clr_n) acc = 0;
      else           acc += dot(pe_a, pe_b);
      check("busy", busy, job_active ? 1 : 0);
      exp_rdy = (edges > 0) && (q.size() < DEPTH);
      check("in_ready", in_ready, exp_rdy ? 1 : 0);
      if (sample) begin
        if (!job_active) begin
          check("spurious_sample", 1, 0);
        end else begin
          check("sample_issued", issued, job_len);
          check("sample_cycle", cyc,
                (job_len == 0 ? clear_cyc : last_issue_cyc) + PE_LAT + 1);
          check("sample_result", acc, exp_acc);
          last_result = acc;
        end
        sample_cnt++;
        job_active = 0;
      end
      if (start && !was_active) begin
        job_active = 1;
        job_len = int'(len);
        issued = 0;
        exp_acc = 0;
        in_clear = 1;
        start_acc++;
      end
      if (in_valid && exp_rdy) begin
        q.push_back({in_a, in_b});
        push_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [63:0] a, input logic [63:0] b);
    int g = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!in_ready && g < 200) begin
      step();
      g++;
    end
    if (g >= 200) check("offer_timeout", g, 0);
    step();
    in_valid = 1'b0;
  endtask

  task automatic start_job(input int l);
    start = 1'b1;
    len = 16'(l);
    step();
    start = 1'b0;
  endtask

  task automatic wait_sample(input int bound);
    int s0 = sample_cnt;
    int g = 0;
    while (sample_cnt == s0 && g < bound) begin
      step();
      g++;
    end
    check("sample_seen", sample_cnt - s0, 1);
  endtask

  initial begin
    int s0, a0, p0, g;
    repeat (3) step();
    check("rst_lit_in_ready", in_ready, 0);
    check("rst_lit_clr_n", pe_clr_n, 0);
    rst_n = 1'b1;
    #1;
    check("release_in_ready", in_ready, 0);
    check("release_clr_n", pe_clr_n, 0);
    step();
    check("post_edge_in_ready", in_ready, 1);
    check("post_edge_clr_n", pe_clr_n, 1);

    // Prefilled job of three pairs.
    for (int i = 0; i < 3; i++) offer(rep(8'd1), rep(8'd2));
    step();
    start_job(3);
    wait_sample(60);
    check("job3_result", last_result, 48);

    // Empty job.
    start_job(0);
    wait_sample(60);
    check("job0_result", last_result, 0);

    // Trickled operands with bubbles between issues.
    start_job(4);
    for (int k = 1; k <= 4; k++) begin
      offer(rep(8'(k)), rep(8'hFF));
      step();
    end
    wait_sample(60);
    check("trickle_result", last_result, -80);
    check("trickle_issued", issued, 4);

    // Fill past depth, then a short job frees room.
    p0 = push_cnt;
    for (int i = 1; i <= 4; i++) offer(rep(8'(i)), rep(8'd1));
    step();
    check("full_pushes", push_cnt - p0, 4);
    check("full_in_ready", in_ready, 0);
    in_valid = 1'b1;
    in_a = rep(8'd5);
    in_b = rep(8'd1);
    start_job(2);
    offer(rep(8'd5), rep(8'd1));
    offer(rep(8'd6), rep(8'd1));
    wait_sample(60);
    check("partial_result", last_result, 24);
    check("partial_pushes", push_cnt - p0, 6);
    check("partial_left", q.size(), 4);
    start_job(4);
    wait_sample(60);
    check("leftover_result", last_result, 144);

    // Reset in the middle of a job.
    offer(rep(8'd5), rep(8'd5));
    offer(rep(8'd5), rep(8'd5));
    start_job(5);
    g = 0;
    while (issued < 2 && g < 100) begin
      step();
      g++;
    end
    check("midjob_issued", issued, 2);
    step();
    s0 = sample_cnt;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    step();
    rst_n = 1'b1;
    repeat (20) step();
    check("midrst_no_sample", sample_cnt - s0, 0);
    offer(rep(8'd7), rep(8'hFE));
    start_job(1);
    wait_sample(60);
    check("after_rst_result", last_result, -112);

    // Starts during FEED and DRAIN are ignored.
    s0 = sample_cnt;
    a0 = start_acc;
    start_job(2);
    repeat (3) step();
    start_job(2);
    offer(rep(8'd2), rep(8'd3));
    offer(rep(8'd2), rep(8'd3));
    repeat (2) step();
    start_job(2);
    wait_sample(60);
    repeat (10) step();
    check("one_sample", sample_cnt - s0, 1);
    check("one_start", start_acc - a0, 1);
    check("ignored_start_result", last_result, 96);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
